uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver for the CPU's serial console and loader path. Configurable frame length and stop-bit count, with an input synchroniser, 3-sample majority voting, and start-bit glitch rejection. Reports framing, parity (optional) and overrun errors. Received words are presented on a valid/ready output held in a one-entry buffer, so the consumer may stall without corrupting the frame in flight.

## Interface
- CLKS_PER_BIT, 5208: clk cycles per bit; legal ≥ 8.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- STOP_BITS, 1: stop bits; legal 1 or 2.
- PARITY_ODD, 0: 0 = even, 1 = odd parity; used only with UART_RX_PARITY_EN.

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx_in  in  1  asynchronous serial input; idle high
- data_out  out  DATA_BITS  received word, LSB-first on line, right-justified
- data_valid  out  1  data_out/frame_err/parity_err valid; held until accepted
- data_ready  in  1  consumer accepts when data_valid && data_ready
- frame_err  out  1  stop bit sampled low for the held word
- parity_err  out  1  parity mismatch for the held word (0 when parity is compiled out)
- overrun  out  1  one-cycle pulse: completed frame dropped, buffer full

## Operation
- rx_in passes through a 2-FF synchroniser (reset value 1) to give rx_s. All logic uses rx_s.
- Bit counter cnt runs 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2, using integer division.
- Each bit is sampled at cnt = HALF-1, HALF and HALF+1. The bit value is the majority of the three samples.
- States: IDLE, START, DATA, PARITY (exists only with the macro), STOP.
  - IDLE: rx_s == 0 → START, cnt = 0.
  - START: at cnt == HALF+1, if majority == 1 → IDLE (glitch rejected, nothing reported); otherwise continue. At cnt == CLKS_PER_BIT-1 → DATA, cnt = 0, bit index = 0.
  - DATA: at the end of each bit period, shift the voted bit into bit position [DATA_BITS-1] of the shift register, shifting existing bits toward bit 0. After DATA_BITS bits → PARITY or STOP.
  - PARITY: at the end of the bit period, store the voted parity bit → STOP.
  - STOP: with STOP_BITS = 2, the first stop bit runs a full period and its voted value ORs into the framing error. The final stop bit is evaluated at cnt == HALF+1; the frame completes there and the state returns to IDLE, so the next start edge may follow immediately.
- Frame completion:
  - Buffer empty, or being accepted in the same cycle: load data_out, frame_err, parity_err; data_valid = 1 on the next cycle.
  - Buffer full and not being accepted: discard the frame; overrun = 1 for one cycle; held contents unchanged.
- Frames with frame_err or parity_err are still delivered.
- data_valid falls the cycle after acceptance. It is never cleared by line activity.
- rst mid-frame: the state machine and buffer clear immediately. A partial frame is never delivered. After rst deasserts, a low rx_s is treated as a new start bit.

## Timing
- Reset values:
  - data_out = 0, data_valid = 0, frame_err = 0, parity_err = 0, overrun = 0
  - State = IDLE, rx_s = 1
- Latency:
  - Start edge at rx_in reaches START after 3 clk cycles (2-FF synchroniser + IDLE detect).
  - data_valid rises 1 cycle after final-stop evaluation, i.e. about (1 + DATA_BITS + P + STOP_BITS − 0.5) bit periods after the start edge, where P is 1 with parity, 0 without.
- Handshake:
  - Data is transferred on any cycle where data_valid && data_ready.
  - data_ready is ignored while data_valid = 0.
- Simultaneous completion and acceptance: the new word replaces the old one with data_valid staying 1. No overrun.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state is present and the frame carries one parity bit after the data bits.
  - parity_err = 1 when the XOR of the data bits and the parity bit ≠ PARITY_ODD.
- UART_RX_PARITY_EN undefined:
  - No parity bit is expected and the PARITY state is not built.
  - parity_err is tied to 0 and PARITY_ODD is ignored.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and DATA_BITS = 8 unless stated.
- Single frame 0xA5, STOP_BITS = 1, data_ready = 1 → data_out = 0xA5 with one-cycle data_valid; frame_err = 0, parity_err = 0.
- Start glitch: rx_in low for 4 cycles, then high → no data_valid and no errors; a subsequent frame 0x3C is received correctly.
- Two back-to-back frames 0x12, 0x34 (next start bit immediately after the stop bit), data_ready held 0 → 0x12 held; overrun pulses once; after accept, data_valid drops and data_out stays 0x12.
- Frame 0x7E with the stop bit driven low → data_out = 0x7E, frame_err = 1. STOP_BITS = 2 with the first stop bit low → frame_err = 1.
- With UART_RX_PARITY_EN, PARITY_ODD = 0: frame 0x01 with parity bit 1 → parity_err = 0; same frame with parity bit 0 → parity_err = 1. DATA_BITS = 5, frame 0x15 → data_out = 5'h15.
- rst asserted mid-DATA of frame 0xFF → all outputs 0 immediately; no data_valid; the next frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if
//   Output-side bundle of the UART receiver: the one-entry word buffer and
//   its valid/ready handshake plus the per-word error flags and the overrun
//   pulse.
//   Parameter:
//     DATA_BITS   width of data_out
//   Signals:
//     data_out    received word, right-justified
//     data_valid  data_out/frame_err/parity_err hold a word
//     data_ready  consumer takes the word when data_valid && data_ready
//     frame_err   stop bit(s) sampled low for the held word
//     parity_err  parity mismatch for the held word
//     overrun     one-cycle pulse: a completed frame was dropped
//   Modports:
//     master      receiver side (drives the word, reads data_ready)
//     slave       consumer side
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output parity_err,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver. The line is synchronised by two flops, each
//   bit is decided by a 3-sample majority around mid-bit, and a start bit
//   whose vote comes out high is dropped as a glitch. Completed words land
//   in a one-entry buffer presented on a valid/ready handshake.
//   Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the
//   data bits and drives parity_err; otherwise parity_err is tied low).
//   Parameters:
//     CLKS_PER_BIT  clk cycles per bit (>= 8)
//     DATA_BITS     data bits per frame (5..9)
//     STOP_BITS     1 or 2
//     PARITY_ODD    0 = even, 1 = odd (parity build only)
//   Ports:
//     clk      system clock
//     rst      asynchronous active-high reset
//     rx_in    asynchronous serial line, idle high
//     rx_bus   output word buffer and handshake (master side)
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_in,
  uart_rx_param_if.master rx_bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LO   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF);
  localparam logic [CW-1:0] CNT_HI   = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  // Reject unsupported parameter sets at elaboration.
  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart_rx_param: unsupported parameter set");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state_reg, state_next;
  logic [1:0]           sync_reg;
  logic                 rx_s;
  logic [CW-1:0]        cnt_reg;
  logic [IW-1:0]        idx_reg;
  logic                 samp_a_reg, samp_b_reg;
  logic                 bit_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 stop_idx_reg;
  logic                 ferr_acc_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg, ferr_reg, perr_reg, overrun_reg;
  logic                 at_lo, at_mid, at_hi, at_end;
  logic                 vote, stop_last, frame_done, perr_calc;

  assign rx_s   = sync_reg[1];
  assign at_lo  = (cnt_reg == CNT_LO);
  assign at_mid = (cnt_reg == CNT_MID);
  assign at_hi  = (cnt_reg == CNT_HI);
  assign at_end = (cnt_reg == CNT_END);

  // Majority of the samples at HALF-1, HALF and the live one at HALF+1.
  assign vote = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s) | (samp_b_reg & rx_s);

  // With one stop bit the first stop is already the final one.
  assign stop_last = (STOP_BITS == 1) || stop_idx_reg;

`ifdef UART_RX_PARITY_EN
  logic par_reg;
  assign perr_calc = ((^shift_reg) ^ par_reg) != (PARITY_ODD != 0);
`else
  assign perr_calc = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (at_hi && vote) state_next = S_IDLE;
        else if (at_end)   state_next = S_DATA;
      end
      S_DATA: begin
        if (at_end && idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_end) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        // Completing at mid-bit lets a new start edge follow right away.
        if (at_hi && stop_last) begin
          frame_done = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg     <= 2'b11;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      samp_a_reg   <= 1'b1;
      samp_b_reg   <= 1'b1;
      bit_reg      <= 1'b1;
      shift_reg    <= '0;
      stop_idx_reg <= 1'b0;
      ferr_acc_reg <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      ferr_reg     <= 1'b0;
      perr_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else begin
      sync_reg <= {sync_reg[0], rx_in};

      // Bit timer restarts on every state change and at each bit boundary.
      if (state_reg == S_IDLE || state_next != state_reg || at_end) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (at_lo)  samp_a_reg <= rx_s;
      if (at_mid) samp_b_reg <= rx_s;
      if (at_hi)  bit_reg    <= vote;

      if (state_reg == S_IDLE) begin
        idx_reg      <= '0;
        stop_idx_reg <= 1'b0;
        ferr_acc_reg <= 1'b0;
      end

      // LSB arrives first, so each new bit enters at the top.
      if (state_reg == S_DATA && at_end) begin
        shift_reg <= {bit_reg, shift_reg[DATA_BITS-1:1]};
        idx_reg   <= idx_reg + 1'b1;
      end

`ifdef UART_RX_PARITY_EN
      if (state_reg == S_PARITY && at_end) par_reg <= bit_reg;
`endif

      // First of two stop bits: accumulate its framing result, run full period.
      if (state_reg == S_STOP && !stop_last) begin
        if (at_hi)  ferr_acc_reg <= ferr_acc_reg | ~vote;
        if (at_end) stop_idx_reg <= 1'b1;
      end

      overrun_reg <= 1'b0;
      if (frame_done) begin
        if (!valid_reg || rx_bus.data_ready) begin
          data_reg  <= shift_reg;
          ferr_reg  <= ferr_acc_reg | ~vote;
          perr_reg  <= perr_calc;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && rx_bus.data_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_bus.data_out   = data_reg;
  assign rx_bus.data_valid = valid_reg;
  assign rx_bus.frame_err  = ferr_reg;
  assign rx_bus.parity_err = perr_reg;
  assign rx_bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
//   Bench for uart_rx_param with CLKS_PER_BIT = 16. Three receivers:
//   u_rx8 (8 data, 1 stop), u_rx8s2 (8 data, 2 stop), u_rx5 (5 data, 1 stop).
//   A table of frames is sent and the accepted words compared; hand-written
//   sequences cover the start glitch, overrun/back-pressure and reset
//   mid-frame. Parity frames are sent when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_line  = 3'b111;
  logic [2:0] rdy_line = 3'b111;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_param_if #(.DATA_BITS(8)) bus_b ();
  uart_rx_param_if #(.DATA_BITS(5)) bus_c ();

  assign bus_a.data_ready = rdy_line[0];
  assign bus_b.data_ready = rdy_line[1];
  assign bus_c.data_ready = rdy_line[2];

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_rx8 (
    .clk(clk), .rst(rst), .rx_in(rx_line[0]), .rx_bus(bus_a.master));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_rx8s2 (
    .clk(clk), .rst(rst), .rx_in(rx_line[1]), .rx_bus(bus_b.master));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) u_rx5 (
    .clk(clk), .rst(rst), .rx_in(rx_line[2]), .rx_bus(bus_c.master));

  logic [8:0] dout [3];
  logic       dv [3], fe [3], pe [3], ov [3];
  assign dout[0] = {1'b0, bus_a.data_out};
  assign dout[1] = {1'b0, bus_b.data_out};
  assign dout[2] = {4'b0, bus_c.data_out};
  assign dv[0] = bus_a.data_valid;  assign dv[1] = bus_b.data_valid;  assign dv[2] = bus_c.data_valid;
  assign fe[0] = bus_a.frame_err;   assign fe[1] = bus_b.frame_err;   assign fe[2] = bus_c.frame_err;
  assign pe[0] = bus_a.parity_err;  assign pe[1] = bus_b.parity_err;  assign pe[2] = bus_c.parity_err;
  assign ov[0] = bus_a.overrun;     assign ov[1] = bus_b.overrun;     assign ov[2] = bus_c.overrun;

  // Accepted-word capture and event counters, sampled mid-cycle.
  int         cap_cnt [3];
  int         vcyc [3];
  int         ov_cnt [3];
  logic [8:0] cap_data [3];
  logic       cap_fe [3], cap_pe [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i]) vcyc[i] <= vcyc[i] + 1;
      if (ov[i]) ov_cnt[i] <= ov_cnt[i] + 1;
      if (dv[i] && rdy_line[i]) begin
        cap_cnt[i]  <= cap_cnt[i] + 1;
        cap_data[i] <= dout[i];
        cap_fe[i]   <= fe[i];
        cap_pe[i]   <= pe[i];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input int sel, input logic b);
    @(negedge clk);
    rx_line[sel] = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic idle_bits(input int sel, input int n);
    @(negedge clk);
    rx_line[sel] = 1'b1;
    repeat (n * CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input logic pb,
                            input logic s1, input logic s2);
    int nb;
    nb = (sel == 2) ? 5 : 8;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
    if (PAR_ON) drive_bit(sel, pb);
    drive_bit(sel, s1);
    if (sel == 1) drive_bit(sel, s2);
  endtask

  typedef struct {
    int         sel;
    logic [8:0] d;
    logic       pb;
    logic       s1;
    logic       s2;
    logic [8:0] exp_d;
    logic       exp_fe;
    logic       exp_pe_par;  // expected parity_err when parity is built
  } vec_t;

  vec_t vecs [11];

  initial begin
    int b_cap, b_ov, b_vc;
    vec_t v;

    vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h07E, 1'b0, 1'b0, 1'b1, 9'h07E, 1'b1, 1'b0};
    vecs[4]  = '{0, 9'h001, 1'b1, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0};
    vecs[5]  = '{0, 9'h001, 1'b0, 1'b1, 1'b1, 9'h001, 1'b0, 1'b1};
    vecs[6]  = '{1, 9'h05A, 1'b0, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b0};
    vecs[7]  = '{1, 9'h05A, 1'b0, 1'b0, 1'b1, 9'h05A, 1'b1, 1'b0};
    vecs[8]  = '{1, 9'h05A, 1'b0, 1'b1, 1'b0, 9'h05A, 1'b1, 1'b0};
    vecs[9]  = '{2, 9'h015, 1'b1, 1'b1, 1'b1, 9'h015, 1'b0, 1'b0};
    vecs[10] = '{2, 9'h00A, 1'b0, 1'b1, 1'b1, 9'h00A, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset data_out",   32'(dout[0]), 32'h0);
    check("reset data_valid", 32'(dv[0]),   32'h0);
    check("reset frame_err",  32'(fe[0]),   32'h0);
    check("reset parity_err", 32'(pe[0]),   32'h0);
    check("reset overrun",    32'(ov[0]),   32'h0);
    $display("txn reset: outputs checked during rst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven frames, consumer always ready
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      b_cap = cap_cnt[v.sel]; b_ov = ov_cnt[v.sel]; b_vc = vcyc[v.sel];
      send_frame(v.sel, v.d, v.pb, v.s1, v.s2);
      idle_bits(v.sel, 1);
      check("vec word count",  32'(cap_cnt[v.sel] - b_cap), 32'd1);
      check("vec valid cycles", 32'(vcyc[v.sel] - b_vc),    32'd1);
      check("vec data_out",    32'(cap_data[v.sel]), 32'(v.exp_d));
      check("vec frame_err",   32'(cap_fe[v.sel]),   32'(v.exp_fe));
      check("vec parity_err",  32'(cap_pe[v.sel]),   32'(PAR_ON & v.exp_pe_par));
      check("vec overrun",     32'(ov_cnt[v.sel] - b_ov), 32'd0);
      $display("txn vec %0d: dut %0d data 0x%0h -> got 0x%0h fe %0b pe %0b",
               i, v.sel, v.d, cap_data[v.sel], cap_fe[v.sel], cap_pe[v.sel]);
    end

    // Start glitch: 4 low cycles, then a good frame
    b_cap = cap_cnt[0]; b_ov = ov_cnt[0];
    @(negedge clk); rx_line[0] = 1'b0;
    repeat (4) @(negedge clk); rx_line[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch no word",    32'(cap_cnt[0] - b_cap), 32'd0);
    check("glitch no overrun", 32'(ov_cnt[0] - b_ov),   32'd0);
    check("glitch valid low",  32'(dv[0]),              32'd0);
    send_frame(0, 9'h03C, 1'b0, 1'b1, 1'b1);
    idle_bits(0, 1);
    check("after glitch count", 32'(cap_cnt[0] - b_cap), 32'd1);
    check("after glitch data",  32'(cap_data[0]),        32'h3C);
    $display("txn glitch: rejected, then 0x3C -> 0x%0h", cap_data[0]);

    // Back-to-back frames with the consumer stalled
    rdy_line[0] = 1'b0;
    b_cap = cap_cnt[0]; b_ov = ov_cnt[0];
    send_frame(0, 9'h012, 1'b0, 1'b1, 1'b1);
    send_frame(0, 9'h034, 1'b1, 1'b1, 1'b1);
    idle_bits(0, 2);
    check("b2b valid held",  32'(dv[0]),              32'd1);
    check("b2b data held",   32'(dout[0]),            32'h12);
    check("b2b overrun",     32'(ov_cnt[0] - b_ov),   32'd1);
    check("b2b not taken",   32'(cap_cnt[0] - b_cap), 32'd0);
    @(posedge clk); #1 rdy_line[0] = 1'b1;
    @(posedge clk); #1 rdy_line[0] = 1'b0;
    @(negedge clk);
    check("b2b valid drop",  32'(dv[0]),              32'd0);
    check("b2b data stays",  32'(dout[0]),            32'h12);
    check("b2b accepted",    32'(cap_cnt[0] - b_cap), 32'd1);
    check("b2b accept data", 32'(cap_data[0]),        32'h12);
    $display("txn b2b: 0x12,0x34 stalled -> held 0x%0h overruns %0d", dout[0], ov_cnt[0] - b_ov);

    // Reset mid-frame with a word held
    send_frame(0, 9'h0C3, 1'b0, 1'b1, 1'b1);
    idle_bits(0, 1);
    check("pre-rst valid", 32'(dv[0]),   32'd1);
    check("pre-rst data",  32'(dout[0]), 32'hC3);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rst async valid", 32'(dv[0]),   32'd0);
    check("rst async data",  32'(dout[0]), 32'h0);
    check("rst async ferr",  32'(fe[0]),   32'd0);
    rx_line[0] = 1'b1;
    rdy_line[0] = 1'b1;
    b_cap = cap_cnt[0];
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    idle_bits(0, 2);
    check("rst no partial", 32'(cap_cnt[0] - b_cap), 32'd0);
    send_frame(0, 9'h055, 1'b0, 1'b1, 1'b1);
    idle_bits(0, 1);
    check("post-rst count", 32'(cap_cnt[0] - b_cap), 32'd1);
    check("post-rst data",  32'(cap_data[0]),        32'h55);
    check("post-rst ferr",  32'(cap_fe[0]),          32'd0);
    $display("txn reset mid-frame: partial 0xFF dropped, then 0x55 -> 0x%0h", cap_data[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
